fifo_uart_tx: RTL and testbench

Byte-stream drain stage that sits directly downstream of the 16-entry 8-bit FIFO and serialises its contents onto an asynchronous serial line (8 data bits, LSB first, optional even parity, 1 stop bit). It pops one byte at a time through the FIFO's `rd`/`dout`/`empty` interface. It also monitors the FIFO's `wr` strobe, because the FIFO gives write priority: a read issued in the same cycle as an accepted write is dropped.

---
 rtl/fifo_uart_tx.sv | 135 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops bytes over rd/dout/empty and sends 8N1 frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even parity bit between data bit 7 and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic       fifo_wr_mon,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n, idx_inc;
  logic [7:0]    shreg, shreg_n;
  logic          txd_n, rd_n, done_n, bit_end;

  assign bit_end = (cnt == CNT_MAX);
  assign idx_inc = idx + 3'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      txd     <= 1'b1;
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      txd     <= txd_n;
      fifo_rd <= rd_n;
      tx_done <= done_n;
    end
  end

  // txd/fifo_rd/tx_done are registered: values chosen here appear in the next state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    txd_n   = txd;
    rd_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (tx_en && !fifo_empty) begin
          state_n = FETCH;
          rd_n    = 1'b1;
        end
      end
      // a write in the same cycle wins inside the FIFO, so our read was lost
      FETCH: state_n = fifo_wr_mon ? IDLE : LOAD;
      LOAD: begin
        shreg_n = fifo_dout;
        txd_n   = 1'b0;
        cnt_n   = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          txd_n   = shreg[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = idx_inc;
          if (idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            txd_n   = ^shreg;
            state_n = PARITY;
`else
            txd_n   = 1'b1;
            state_n = STOP;
`endif
          end else begin
            txd_n = shreg[idx_inc];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small write-priority FIFO model feeding it (CLKS_PER_BIT=4).
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0, rst = 1'b0, tx_en = 1'b0, wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       fifo_empty, fifo_rd, txd, busy, tx_done;
  logic [7:0] fifo_dout;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_wr_mon(wr), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  // FIFO model: write has priority, a read in the same cycle is dropped
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0, rp = 4'd0;
  logic [4:0] fcnt = 5'd0;
  logic [7:0] dout_q = 8'h00;
  logic       wr_ok, rd_ok;
  assign wr_ok      = wr && (fcnt != 5'd16);
  assign rd_ok      = fifo_rd && !wr && (fcnt != 5'd0);
  assign fifo_empty = (fcnt == 5'd0);
  assign fifo_dout  = dout_q;

  always @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= din;
      wp      <= wp + 4'd1;
    end
    if (rd_ok) begin
      dout_q <= mem[rp];
      rp     <= rp + 4'd1;
    end
    if (wr_ok) fcnt <= fcnt + 5'd1;
    else if (rd_ok) fcnt <= fcnt - 5'd1;
  end

  int rd_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (fifo_rd) rd_cnt <= rd_cnt + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [0:7] lsb_first;   // data bits in line order
    logic       par;
  } vec_t;
  vec_t tbl[7];

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [0:10] exp_frame(input vec_t v);
`ifdef FIFO_UART_TX_PARITY_EN
    return {1'b0, v.lsb_first, v.par, 1'b1};
`else
    return {1'b0, v.lsb_first, 1'b1, 1'b0};
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  // waits for the start bit, samples every cycle of the frame, then checks the tx_done cycle
  task automatic capture(output logic [0:10] obs, output int waited, output int glitches);
    logic [0:43] s;
    obs = '0;
    glitches = 0;
    s = '0;
    for (waited = 0; waited < 300; waited++) begin
      @(negedge clk);
      if (txd === 1'b0) break;
    end
    if (waited >= 300) begin
      check("start_seen", {63'd0, txd}, 64'd0);
      return;
    end
    s[0] = txd;
    for (int i = 1; i < FB * CPB; i++) begin
      @(negedge clk);
      s[i] = txd;
    end
    for (int k = 0; k < FB; k++) begin
      obs[k] = s[k*CPB];
      for (int j = 1; j < CPB; j++)
        if (s[k*CPB+j] !== s[k*CPB]) glitches++;
    end
    @(negedge clk);
    check("done_pulse", {63'd0, tx_done}, 64'd1);
    check("idle_high", {63'd0, txd}, 64'd1);
  endtask

  logic [0:10] obs;
  int w, g, r0, d0, k;

  initial begin
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h01, 8'b10000000, 1'b1};
    tbl[2] = '{8'h80, 8'b00000001, 1'b1};
    tbl[3] = '{8'h3C, 8'b00111100, 1'b0};
    tbl[4] = '{8'h00, 8'b00000000, 1'b0};
    tbl[5] = '{8'hFF, 8'b11111111, 1'b0};
    tbl[6] = '{8'h11, 8'b10001000, 1'b0};

    // reset held with a non-empty FIFO
    tx_en = 1'b1;
    @(negedge clk);
    push(tbl[0].data);
    @(negedge clk);
    check("rst_txd", {63'd0, txd}, 64'd1);
    check("rst_rd", {63'd0, fifo_rd}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, tx_done}, 64'd0);
    check("rst_rd_cnt", rd_cnt, 0);
    r0 = rd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rel_fetch_rd", {63'd0, fifo_rd}, 64'd1);
    check("rel_fetch_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("rel_load_rd", {63'd0, fifo_rd}, 64'd0);
    check("rel_load_txd", {63'd0, txd}, 64'd1);
    capture(obs, w, g);
    check("rel_first_fall", w, 0);
    check("rel_frame", obs, exp_frame(tbl[0]));
    check("rel_width", g, 0);
    check("rel_rd_pulses", rd_cnt - r0, 1);

    // single-byte frames from the vector table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      r0 = rd_cnt;
      d0 = done_cnt;
      push(tbl[i].data);
      capture(obs, w, g);
      check($sformatf("solo%0d_latency", i), w, 2);
      check($sformatf("solo%0d_frame", i), obs, exp_frame(tbl[i]));
      check($sformatf("solo%0d_width", i), g, 0);
      @(negedge clk);
      check($sformatf("solo%0d_done_low", i), {63'd0, tx_done}, 64'd0);
      check($sformatf("solo%0d_rd", i), rd_cnt - r0, 1);
      check($sformatf("solo%0d_done", i), done_cnt - d0, 1);
    end

    // three preloaded bytes drained back to back
    tx_en = 1'b0;
    push(tbl[4].data);
    push(tbl[5].data);
    push(tbl[3].data);
    r0 = rd_cnt;
    d0 = done_cnt;
    tx_en = 1'b1;
    capture(obs, w, g);
    check("b2b0_frame", obs, exp_frame(tbl[4]));
    capture(obs, w, g);
    check("b2b1_gap", w, 2);
    check("b2b1_frame", obs, exp_frame(tbl[5]));
    capture(obs, w, g);
    check("b2b2_gap", w, 2);
    check("b2b2_frame", obs, exp_frame(tbl[3]));
    @(negedge clk);
    check("b2b_busy_end", {63'd0, busy}, 64'd0);
    check("b2b_rd", rd_cnt - r0, 3);
    check("b2b_done", done_cnt - d0, 3);

    // write collides with the FETCH read: read retried, head byte kept
    r0 = rd_cnt;
    d0 = done_cnt;
    push(tbl[0].data);
    @(negedge clk);
    check("drop_fetch_rd", {63'd0, fifo_rd}, 64'd1);
    din = tbl[6].data;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
    check("drop_rd_low", {63'd0, fifo_rd}, 64'd0);
    check("drop_idle", {63'd0, busy}, 64'd0);
    capture(obs, w, g);
    check("drop_retry_lat", w, 2);
    check("drop_head", obs, exp_frame(tbl[0]));
    capture(obs, w, g);
    check("drop_next", obs, exp_frame(tbl[6]));
    @(negedge clk);
    check("drop_rd", rd_cnt - r0, 3);
    check("drop_done", done_cnt - d0, 2);

    // tx_en dropped mid-frame with two bytes queued
    tx_en = 1'b0;
    push(tbl[1].data);
    push(tbl[2].data);
    r0 = rd_cnt;
    tx_en = 1'b1;
    k = 0;
    while (txd !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    tx_en = 1'b0;
    k = 0;
    while (tx_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("en_done_seen", {63'd0, tx_done}, 64'd1);
    repeat (20) @(negedge clk);
    check("en_hold_rd", rd_cnt - r0, 1);
    check("en_hold_busy", {63'd0, busy}, 64'd0);
    check("en_hold_txd", {63'd0, txd}, 64'd1);
    tx_en = 1'b1;
    capture(obs, w, g);
    check("en_resume_lat", w, 2);
    check("en_resume_frame", obs, exp_frame(tbl[2]));
    @(negedge clk);

    // asynchronous reset in the middle of the data bits
    r0 = rd_cnt;
    push(tbl[4].data);
    k = 0;
    while (txd !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    check("arst_pre_txd", {63'd0, txd}, 64'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_txd", {63'd0, txd}, 64'd1);
    check("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_lost_txd", {63'd0, txd}, 64'd1);
    check("arst_lost_rd", rd_cnt - r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
